rf_write_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline's writeback result and results returned late by the multi-cycle execution unit (mul/div). Multi-cycle results are queued in a small FIFO. The pipeline normally has priority, and a starvation counter forces a FIFO drain by stalling writeback. The arbiter sits between the writeback mux output and the register file write port, and registers the write port.

---
 rtl/rf_write_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs. queued multi-cycle results.
// WB normally wins; a starvation counter forces the FIFO head through by stalling WB.
module rf_write_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic [4:0]                 wb_addr,
  input  logic [31:0]                wb_data,
  output logic                       wb_stall,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [4:0]                 mc_addr,
  input  logic [31:0]                mc_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned StvW = $clog2(STARVE_MAX + 1);

  logic [4:0]      addr_mem [DEPTH];
  logic [31:0]     data_mem [DEPTH];

  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [StvW-1:0] starve_q, starve_d;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [31:0]     rf_wdata_q;

  logic            head_vld;
  logic            grant_wb;
  logic            grant_head;
  logic            granted;
  logic            push;
  logic [4:0]      g_addr;
  logic [31:0]     g_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign head_vld = (count_q != '0);
  assign mc_ready = (count_q != CntW'(DEPTH));
  assign push     = mc_valid && mc_ready;

  always_comb begin
    grant_wb   = 1'b0;
    grant_head = 1'b0;
    wb_stall   = 1'b0;
    if (head_vld && wb_valid) begin
      if (starve_q == StvW'(STARVE_MAX)) begin
        grant_head = 1'b1;
        wb_stall   = 1'b1;
      end else begin
        grant_wb = 1'b1;
      end
    end else if (head_vld) begin
      grant_head = 1'b1;
    end else if (wb_valid) begin
      grant_wb = 1'b1;
    end
  end

  assign granted = grant_wb || grant_head;
  assign g_addr  = grant_head ? addr_mem[rptr_q] : wb_addr;
  assign g_data  = grant_head ? data_mem[rptr_q] : wb_data;

  always_comb begin
    count_d  = count_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    starve_d = starve_q;
    if (push) begin
      wptr_d = ptr_inc(wptr_q);
    end
    if (grant_head) begin
      rptr_d = ptr_inc(rptr_q);
    end
    unique case ({push, grant_head})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    // Starvation is judged on the pre-edge occupancy; a same-cycle push does not count.
    if (!head_vld || grant_head) begin
      starve_d = '0;
    end else if (starve_q != StvW'(STARVE_MAX)) begin
      starve_d = starve_q + StvW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= mc_addr;
      data_mem[wptr_q] <= mc_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      count_q  <= count_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      starve_q <= starve_d;
      // x0 grants are consumed but never written.
      rf_we_q  <= granted && (g_addr != 5'd0);
      if (granted) begin
        rf_waddr_q <= g_addr;
        rf_wdata_q <= g_data;
      end
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pending_cnt = count_q;

endmodule
